// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and its forwarding compare.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  // Sequencer states; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STALL  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } hazState_t;

  // Execute operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
  localparam logic [1:0] FWD_MEM = 2'b01;  // memory-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // ResultW

  localparam logic [3:0] OP_HALT_DEFAULT = 4'hF;

endpackage

// File: rtl/hazard_forward_unit.sv
// Forwarding select for one execute operand; memory stage beats writeback.
// Latency: purely combinational.
// Backpressure: none; the select simply follows its inputs.
module hazard_forward_unit
  import hazard_pkg::*;
(
  input  logic [3:0] srcE,
  input  logic [3:0] destAddM,
  input  logic       RegWriteM,
  input  logic [3:0] destAddW,
  input  logic       RegWriteW,
  output logic [1:0] fwdSel
);

  // Youngest matching producer wins; register 0 is an ordinary register here
  always_comb begin
    fwdSel = FWD_RF;
    if (RegWriteM && (destAddM == srcE)) begin
      fwdSel = FWD_MEM;
    end else if (RegWriteW && (destAddW == srcE)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing/hazard control for the 5-stage pipeline: boot hold-off, load-use stall, branch flush, halt drain, forwarding.
// Latency: hazard outputs are combinational in the detecting cycle; state changes on the next rising clk edge.
// Backpressure: a load-use hazard drops enable and injects one execute bubble; BOOT, DRAIN and HALTED hold enable low. Optional HAZARD_PERF_EN adds event counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [3:0]  OP_HALT      = OP_HALT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcodeD,
  input  logic [3:0]  srcAddD1,
  input  logic [3:0]  srcAddD2,
  input  logic        useSrc2D,
  input  logic        branchTakenD,
  input  logic [3:0]  destAddE,
  input  logic        RegWriteE,
  input  logic        MemToRegE,
  input  logic [3:0]  destAddM,
  input  logic        RegWriteM,
  input  logic [3:0]  destAddW,
  input  logic        RegWriteW,
  output logic        enable,
  output logic        flushD,
  output logic        flushC,
  output logic [1:0]  fwdSel1E,
  output logic [1:0]  fwdSel2E,
  output logic        halted,
  output logic [2:0]  state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount,
  output logic [15:0] cycleCount
`endif
);

  // A zero-length boot or drain still spends one cycle in that state
  localparam logic [15:0] BOOT_LAST  = (BOOT_CYCLES  > 1) ? 16'(BOOT_CYCLES  - 1) : 16'd0;
  localparam logic [15:0] DRAIN_LAST = (DRAIN_CYCLES > 1) ? 16'(DRAIN_CYCLES - 1) : 16'd0;

  hazState_t   curState;
  hazState_t   nextState;
  logic [15:0] bootCnt;
  logic [15:0] drainCnt;
  logic [3:0]  srcE1;
  logic [3:0]  srcE2;
  logic        loadUse;
  logic [1:0]  fwdRaw1;
  logic [1:0]  fwdRaw2;

  // Load in execute whose destination is read by the decode instruction
  assign loadUse = MemToRegE & RegWriteE &
                   ((destAddE == srcAddD1) | (useSrc2D & (destAddE == srcAddD2)));

  assign state = curState;

  // State register plus boot/drain dwell counters, cleared whenever their state is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState <= ST_BOOT;
      bootCnt  <= '0;
      drainCnt <= '0;
    end else begin
      curState <= nextState;
      bootCnt  <= ((curState == ST_BOOT)  && (nextState == ST_BOOT))  ? bootCnt  + 16'd1 : '0;
      drainCnt <= ((curState == ST_DRAIN) && (nextState == ST_DRAIN)) ? drainCnt + 16'd1 : '0;
    end
  end

  // Next state and pipeline controls; defaults describe a frozen pipeline with a bubble
  always_comb begin
    nextState = curState;
    enable    = 1'b0;
    flushD    = 1'b0;
    flushC    = 1'b1;
    halted    = 1'b0;
    case (curState)
      ST_BOOT: begin
        if (bootCnt == BOOT_LAST) nextState = ST_RUN;
      end
      ST_RUN: begin
        if (loadUse) begin
          // Load-use beats a same-cycle branch; the branch is seen again next cycle
          nextState = ST_STALL;
        end else begin
          enable = 1'b1;
          flushC = 1'b0;
          flushD = branchTakenD;
          // A halt in a taken branch's shadow is speculative and ignored
          if (!branchTakenD && (opcodeD == OP_HALT)) nextState = ST_DRAIN;
        end
      end
      ST_STALL: begin
        // Execute now holds the bubble, so no load-use check this cycle
        enable    = 1'b1;
        flushC    = 1'b0;
        flushD    = branchTakenD;
        nextState = ST_RUN;
      end
      ST_DRAIN: begin
        if (drainCnt == DRAIN_LAST) nextState = ST_HALTED;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        nextState = ST_BOOT;
      end
    endcase
  end

  // Execute-stage copies of the decode source addresses, advancing with the pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcE1 <= '0;
      srcE2 <= '0;
    end else if (enable) begin
      srcE1 <= srcAddD1;
      srcE2 <= srcAddD2;
    end
  end

  hazard_forward_unit fwdUnit1 (
    .srcE      (srcE1),
    .destAddM  (destAddM),
    .RegWriteM (RegWriteM),
    .destAddW  (destAddW),
    .RegWriteW (RegWriteW),
    .fwdSel    (fwdRaw1)
  );

  hazard_forward_unit fwdUnit2 (
    .srcE      (srcE2),
    .destAddM  (destAddM),
    .RegWriteM (RegWriteM),
    .destAddW  (destAddW),
    .RegWriteW (RegWriteW),
    .fwdSel    (fwdRaw2)
  );

  // No instruction has reached execute during boot, so read the register file
  assign fwdSel1E = (curState == ST_BOOT) ? FWD_RF : fwdRaw1;
  assign fwdSel2E = (curState == ST_BOOT) ? FWD_RF : fwdRaw2;

`ifdef HAZARD_PERF_EN
  // Saturating event counters; HALTED generates no events so they freeze there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
      flushCount <= '0;
      cycleCount <= '0;
    end else if (curState != ST_HALTED) begin
      if ((curState == ST_RUN) && loadUse && (stallCount != 16'hFFFF))
        stallCount <= stallCount + 16'd1;
      if (flushD && (flushCount != 16'hFFFF))
        flushCount <= flushCount + 16'd1;
      if (((curState == ST_RUN) || (curState == ST_STALL)) && (cycleCount != 16'hFFFF))
        cycleCount <= cycleCount + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing and hazard controller for the 5-stage 16-bit pipeline (Fetch, Decode, Execute, Memory, WriteBack).
- Generates the PC/decode-register enable and the execute-register flush (bubble).
- Generates the execute-stage forwarding selects.
- Runs a boot hold-off after reset and a halt/drain sequence.
- Sits beside the control unit. Consumes decode-stage register addresses and downstream destination/write-enable bits.

Parameters:
- BOOT_CYCLES, 4: cycles enable is held low after reset release.
- DRAIN_CYCLES, 3: cycles after a halt opcode leaves decode before HALTED is entered.
- OP_HALT, 4'hF: opcode value treated as halt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcodeD  in  4  opcode of the instruction in decode.
- srcAddD1  in  4  decode source register 1.
- srcAddD2  in  4  decode source register 2.
- useSrc2D  in  1  1 = decode instruction reads srcAddD2 (0 for immediate forms).
- branchTakenD  in  1  branch resolved taken in decode.
- destAddE, RegWriteE, MemToRegE  in  4/1/1  execute-stage destination and controls.
- destAddM, RegWriteM  in  4/1  memory-stage destination and write enable.
- destAddW, RegWriteW  in  1... see below: destAddW is 4 bits, RegWriteW is 1 bit.
- enable  out  1  PC and decode-register enable.
- flushD  out  1  clears the decode register (branch shadow).
- flushC  out  1  bubble into the execute register.
- fwdSel1E, fwdSel2E  out  2  execute operand select: 00 register file, 01 memory-stage ALU result, 10 ResultW.
- halted  out  1  high in HALTED.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (reset low, asynchronous):
  - state=BOOT, boot counter=0, drain counter=0.
  - enable=0, flushD=0, flushC=1, halted=0, fwdSel=00.
- State encoding: BOOT=0, RUN=1, STALL=2, DRAIN=3, HALTED=4.
- FSM states (registered, evaluated on the rising clk edge):
  - BOOT: enable=0, flushC=1. Counter increments each cycle. When counter==BOOT_CYCLES-1, go to RUN next edge. BOOT_CYCLES=0 is treated as 1.
  - RUN: enable=1, flushC=0, unless a hazard output is asserted combinationally (rules below).
  - STALL: entered for exactly one cycle after a load-use hazard. enable=1, flushC=0. Returns to RUN. Does not re-detect against the same bubble.
  - DRAIN: entered when opcodeD==OP_HALT in RUN with no stall. enable=0, flushC=1. Drain counter counts DRAIN_CYCLES, then HALTED.
  - HALTED: enable=0, flushC=1, halted=1. Left only by reset.
- Load-use hazard (RUN only, combinational):
  - Condition: MemToRegE & RegWriteE & (destAddE==srcAddD1 | (useSrc2D & destAddE==srcAddD2)).
  - Response: enable=0 and flushC=1 the same cycle; next state STALL.
  - Total penalty: 1 cycle.
- Branch (RUN or STALL):
  - branchTakenD=1 -> flushD=1 for that cycle only. enable is unaffected.
  - Load-use and branch together: load-use wins. flushD is suppressed; the branch re-evaluates next cycle.
- Halt and branch together: the branch wins (flushD=1, stay RUN). The halt is speculative.
- Forwarding (combinational, per operand; srcE addresses are registered copies of srcAddD1/2, captured when enable=1):
  - Memory stage has priority: RegWriteM & destAddM==srcE -> 01.
  - Else RegWriteW & destAddW==srcE -> 10.
  - Else 00.
  - Register 0 is a normal register (no zero-register exclusion).
- Reset asserted mid-operation: returns to BOOT immediately; all counters are cleared.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- With the macro defined, extra outputs are added:
  - stallCount (16 bit): load-use stalls.
  - flushCount (16 bit): taken-branch flushes.
  - cycleCount (16 bit): cycles in RUN or STALL.
- Counter rules: saturate at 16'hFFFF, clear on reset, freeze in HALTED.
- Without the macro, none of these ports or registers exist.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encodings;
  - the fwdSel constants FWD_RF, FWD_MEM, FWD_WB;
  - the OP_HALT default.
- One natural sub-module: hazard_forward_unit, the combinational forwarding compare, instantiated once per operand.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> enable=0 and flushC=1 for 4 edges, then enable=1 and state=RUN on the 5th cycle.
- Load-use: MemToRegE=1, RegWriteE=1, destAddE=3, srcAddD1=3 -> enable=0 and flushC=1 for 1 cycle, state=STALL for 1 cycle, then RUN. stallCount=1 when HAZARD_PERF_EN is defined.
- Forwarding priority: destAddM=5 with RegWriteM=1, and destAddW=5 with RegWriteW=1, srcE1=5 -> fwdSel1E=01. Drop RegWriteM -> fwdSel1E=10.
- Branch plus load-use in the same cycle -> flushD=0, enable=0. Next cycle, branchTakenD still 1 -> flushD=1.
- opcodeD=4'hF in RUN, DRAIN_CYCLES=3 -> DRAIN for 3 cycles, then halted=1. Pulsing reset low mid-DRAIN returns the block to BOOT at once.
